// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES pad reader: button bit positions as the core
// consumes them, the reader FSM encoding, and a small elaboration helper.
package nes_pad_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        GAP,
        PULSE_HI,
        PULSE_LO,
        COMMIT
    } pad_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nes_pad_reader_if.sv
// Physical pad pins: the reader drives latch/pulse and receives serial data.
interface nes_pad_reader_if;
    logic padLatch;
    logic padPulse;
    logic padData;

    modport master (output padLatch, output padPulse, input padData);
    modport slave  (input padLatch, input padPulse, output padData);
endinterface

// File: rtl/nes_pad_reader_sync_2ff.sv
// Generic two-stage synchronizer; resets to 1 so an idle pad line reads as released.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [1:0] stagesReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stagesReg <= 2'b11;
        end else begin
            stagesReg <= {stagesReg[0], d};
        end
    end

    assign q = stagesReg[1];
endmodule

// File: rtl/nes_pad_reader.sv
// Reads a 4021-style NES pad once per frame and publishes the 8 buttons atomically.
module nes_pad_reader
    import nes_pad_pkg::*;
#(
    parameter int LATCH_CYCLES      = 302,
    parameter int PULSE_HALF_CYCLES = 151
) (
    input  logic             pixelClock,
    input  logic             reset,
    input  logic             vSyncStart,
    nes_pad_reader_if.master pad,
    output logic [7:0]       buttons,
    output logic             valid
);
    localparam int TIMER_W = $clog2(max_int(LATCH_CYCLES, PULSE_HALF_CYCLES)) + 1;
    localparam logic [TIMER_W-1:0] LATCH_LOAD = TIMER_W'(LATCH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HALF_LOAD  = TIMER_W'(PULSE_HALF_CYCLES - 1);

    pad_state_t         stateReg, stateNext;
    logic [TIMER_W-1:0] timerReg, timerNext;
    logic [2:0]         bitReg, bitNext;
    logic [7:0]         shiftReg, shiftNext;
    logic [7:0]         buttonsReg, buttonsNext;
    logic               validReg, validNext;
    logic               lastTick;
    logic               padSync;

    sync_2ff padSyncInst (
        .clk   (pixelClock),
        .reset (reset),
        .d     (pad.padData),
        .q     (padSync)
    );

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            stateReg   <= IDLE;
            timerReg   <= '0;
            bitReg     <= '0;
            shiftReg   <= '0;
            buttonsReg <= '0;
            validReg   <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            timerReg   <= timerNext;
            bitReg     <= bitNext;
            shiftReg   <= shiftNext;
            buttonsReg <= buttonsNext;
            validReg   <= validNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        timerNext   = timerReg;
        bitNext     = bitReg;
        shiftNext   = shiftReg;
        buttonsNext = buttonsReg;
        validNext   = 1'b0;
        lastTick    = (timerReg == '0);
        if (!lastTick) begin
            timerNext = timerReg - TIMER_W'(1);
        end

        unique case (stateReg)
            IDLE: begin
                if (vSyncStart) begin
                    stateNext = LATCH;
                    timerNext = LATCH_LOAD;
                    bitNext   = '0;
                end
            end
            LATCH: begin
                if (lastTick) begin
                    stateNext = GAP;
                    timerNext = HALF_LOAD;
                end
            end
            GAP: begin
                // The pad presents A as soon as the latch drops, before any pulse.
                if (lastTick) begin
                    shiftNext[BTN_A] = ~padSync;
                    bitNext          = 3'd1;
                    stateNext        = PULSE_HI;
                    timerNext        = HALF_LOAD;
                end
            end
            PULSE_HI: begin
                if (lastTick) begin
                    stateNext = PULSE_LO;
                    timerNext = HALF_LOAD;
                end
            end
            PULSE_LO: begin
                if (lastTick) begin
                    shiftNext[bitReg] = ~padSync;
                    if (bitReg == 3'(BTN_RIGHT)) begin
                        // Bypass the final bit so buttons/valid are live during COMMIT itself.
                        stateNext   = COMMIT;
                        timerNext   = '0;
                        buttonsNext = shiftNext;
                        validNext   = 1'b1;
                    end else begin
                        stateNext = PULSE_HI;
                        bitNext   = bitReg + 3'd1;
                        timerNext = HALF_LOAD;
                    end
                end
            end
            COMMIT: begin
                stateNext = IDLE;
                timerNext = '0;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign pad.padLatch = (stateReg == LATCH);
    assign pad.padPulse = (stateReg == PULSE_HI);
    assign buttons      = buttonsReg;
    assign valid        = validReg;
endmodule

// File: tb/tb_nes_pad_reader.sv
// Random/directed bench for nes_pad_reader against a cycle-offset reference model.
module tb_nes_pad_reader;
    localparam int L          = 4;
    localparam int H          = 3;
    localparam int COMMIT_OFS = L + 15 * H;

    logic       pixelClock   = 1'b0;
    logic       reset        = 1'b1;
    logic       vSyncStart   = 1'b0;
    logic [7:0] buttons;
    logic       valid;
    logic [7:0] padPattern   = 8'hFF;
    logic       padConnected = 1'b1;
    logic [7:0] padShift     = 8'hFF;
    int         edgeCnt      = 0;
    int         total        = 0;
    int         bad          = 0;

    // reference model state
    bit         modelOk      = 1'b0;
    bit         active       = 1'b0;
    bit         wasActive    = 1'b0;
    bit         prevPulse    = 1'b0;
    bit         expLatch, expPulse, expValid;
    int         startEdge    = 0;
    int         d, r;
    int         pulseCnt     = 0;
    logic [7:0] committed    = 8'h00;
    logic [7:0] newVal       = 8'h00;
    logic [7:0] expButtons;

    nes_pad_reader_if pif();

    nes_pad_reader #(
        .LATCH_CYCLES      (L),
        .PULSE_HALF_CYCLES (H)
    ) dut (
        .pixelClock (pixelClock),
        .reset      (reset),
        .vSyncStart (vSyncStart),
        .pad        (pif),
        .buttons    (buttons),
        .valid      (valid)
    );

    always #5 pixelClock = ~pixelClock;
    always @(posedge pixelClock) edgeCnt <= edgeCnt + 1;

    // 4021 pad: parallel load when latch drops, shift toward bit 0 on pulse rise.
    assign pif.padData = padConnected ? padShift[0] : 1'b1;
    always @(negedge pif.padLatch or posedge pif.padPulse) begin
        if (pif.padPulse === 1'b1) padShift <= {1'b1, padShift[7:1]};
        else                       padShift <= padPattern;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edgeCnt, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixelClock);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic pulse_vsync();
        vSyncStart = 1'b1;
        tick();
        vSyncStart = 1'b0;
    endtask

    // Expected outputs in the period after edge e follow from the offset to the start edge.
    initial begin : monitor
        forever begin
            @(negedge pixelClock);
            wasActive = active;
            if (modelOk) begin
                expLatch   = 1'b0;
                expPulse   = 1'b0;
                expValid   = 1'b0;
                expButtons = committed;
                if (active) begin
                    d        = edgeCnt - startEdge;
                    r        = d - L - H;
                    expLatch = (d < L);
                    expPulse = (r >= 0) && (r < 14 * H) && ((r % (2 * H)) < H);
                    expValid = (d == COMMIT_OFS);
                    if (expValid) expButtons = newVal;
                end
                check_eq("padLatch", 32'(pif.padLatch), 32'(expLatch));
                check_eq("padPulse", 32'(pif.padPulse), 32'(expPulse));
                check_eq("valid",    32'(valid),        32'(expValid));
                check_eq("buttons",  32'(buttons),      32'(expButtons));
                if (active && pif.padPulse === 1'b1 && !prevPulse) pulseCnt++;
                if (expValid) begin
                    check_eq("pulse_count", 32'(pulseCnt), 32'd7);
                    $display("txn start=%0d buttons=%02h expected=%02h pad=%s",
                             startEdge, buttons, newVal, padConnected ? "connected" : "open");
                    committed = newVal;
                    active    = 1'b0;
                end
            end
            prevPulse = (pif.padPulse === 1'b1);
            if (reset) begin
                if (active) $display("txn start=%0d aborted by reset at edge %0d", startEdge, edgeCnt + 1);
                modelOk   = 1'b1;
                active    = 1'b0;
                committed = 8'h00;
            end else if (modelOk && !wasActive && vSyncStart) begin
                active    = 1'b1;
                startEdge = edgeCnt + 1;
                newVal    = padConnected ? ~padPattern : 8'h00;
                pulseCnt  = 0;
            end
        end
    end

    initial begin : stimulus
        int j, gap;
        // reset held three edges while vSyncStart toggles
        reset = 1'b1;
        vSyncStart = 1'b1; tick();
        vSyncStart = 1'b0; tick();
        vSyncStart = 1'b1; tick();
        vSyncStart = 1'b0; reset = 1'b0;
        idle(2);

        // A + Start pressed
        padPattern = 8'hF6; pulse_vsync(); idle(COMMIT_OFS + 1);

        // disconnected pad
        padConnected = 1'b0; padPattern = 8'($urandom); pulse_vsync(); idle(COMMIT_OFS + 1);
        padConnected = 1'b1;

        // 8'h09 reading followed by 8'hA5 pressed
        padPattern = 8'hF6; pulse_vsync(); idle(COMMIT_OFS + 1);
        padPattern = 8'h5A; pulse_vsync(); idle(COMMIT_OFS + 1);

        // repeat strobe at N+10 ignored, fresh strobe at N+51 honoured
        padPattern = 8'($urandom); pulse_vsync(); idle(9); pulse_vsync(); idle(40);
        padPattern = 8'($urandom); pulse_vsync(); idle(COMMIT_OFS + 1);

        // reset lands at N+20
        padPattern = 8'h00; pulse_vsync(); idle(19);
        reset = 1'b1; tick(); reset = 1'b0;
        idle(COMMIT_OFS + 6);

        // random patterns, random stray strobes (including during COMMIT), back-to-back starts
        for (int i = 0; i < 8; i++) begin
            padPattern   = 8'($urandom);
            padConnected = ($urandom_range(0, 4) != 0);
            j            = $urandom_range(1, 50);
            gap          = $urandom_range(0, 3);
            pulse_vsync();
            idle(j - 1);
            pulse_vsync();
            idle(50 - j + gap);
        end
        padConnected = 1'b1;
        idle(COMMIT_OFS + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Reads a physical NES controller (4021-style parallel-in/serial-out pad) through its latch/pulse/data pins.
- Delivers an 8-bit active-high button vector in the same bit order the NES core consumes: A=0, B=1, Select=2, Start=3, Up=4, Down=5, Left=6, Right=7.
- Runs one read transaction per frame, triggered by vSyncStart.
- The vector is updated atomically, so the core never sees a partially shifted value.

Parameters:
- LATCH_CYCLES, 302, number of pixelClock cycles padLatch is held high (12 us at 25.175 MHz); minimum 1.
- PULSE_HALF_CYCLES, 151, cycles per half-period of padPulse (6 us); minimum 3, to cover synchronizer latency.

Ports:
- pixelClock  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- vSyncStart  input  1  one-cycle frame-start strobe; requests a read.
- padData  input  1  serial data from the pad; active-low (0 = pressed); asynchronous.
- padLatch  output  1  parallel-load strobe to the pad; active-high.
- padPulse  output  1  shift clock to the pad; the pad shifts on its rising edge.
- buttons  output  8  last complete reading; 1 = pressed.
- valid  output  1  one-cycle pulse, coincident with each buttons update.

Behaviour:
- Reset:
  - Applies on any cycle with reset=1, including mid-transaction.
  - Next cycle: padLatch=0, padPulse=0, buttons=8'h00, valid=0, FSM=IDLE, shift register, bit counter and timer cleared.
  - reset has priority over vSyncStart.
- Input synchronization:
  - padData passes through a 2-flop synchronizer; all sampling uses the synchronized value.
  - Pin-to-sample latency is 2 cycles.
- FSM states: IDLE, LATCH, GAP, PULSE_HI, PULSE_LO, COMMIT.
- IDLE: outputs low; on vSyncStart=1 at edge N, go to LATCH.
- LATCH:
  - padLatch=1 for exactly LATCH_CYCLES cycles (N+1 .. N+LATCH_CYCLES).
  - Then go to GAP.
- GAP:
  - padLatch=0, padPulse=0 for PULSE_HALF_CYCLES cycles.
  - On its last cycle, sample bit 0 (A).
- PULSE_HI: padPulse=1 for PULSE_HALF_CYCLES cycles.
- PULSE_LO:
  - padPulse=0 for PULSE_HALF_CYCLES cycles.
  - On its last cycle, sample bit k (k = 1..7).
  - If k=7, go to COMMIT; otherwise go to PULSE_HI and increment k.
- Pulse count: exactly 7 padPulse pulses per transaction (no 8th pulse).
- Sample timing:
  - Bit k is sampled at cycle N + LATCH_CYCLES + PULSE_HALF_CYCLES + 2*PULSE_HALF_CYCLES*k.
  - Sampled value = inverted synchronized padData, stored at shift register index k.
- COMMIT:
  - One cycle at N + LATCH_CYCLES + 15*PULSE_HALF_CYCLES + 1.
  - Registered outputs take effect the same cycle: buttons <= shift register, valid=1.
  - Then return to IDLE.
- buttons holds its previous value for the entire transaction.
- vSyncStart in any non-IDLE state is ignored; there is no queuing.
- vSyncStart on the cycle after COMMIT (FSM already in IDLE) starts a new transaction normally.
- Disconnected pad: padData pulled high reads as all released, buttons=8'h00; not an error.
- Timer:
  - A single down-counter, width clog2(max(LATCH_CYCLES, PULSE_HALF_CYCLES)) + 1.
  - Reloaded on every state entry.
- Bit counter: 3 bits; no wrap occurs because COMMIT follows k=7.

Decomposition:
- Package nes_pad_pkg holds:
  - button index constants BTN_A..BTN_RIGHT (0..7), shared with the existing NES button mapping logic;
  - the FSM state encoding.
- Sub-module sync_2ff: a generic 1-bit, two-stage synchronizer with synchronous reset to 1 (the released level), reusable elsewhere.

Test Plan:
All scenarios use LATCH_CYCLES=4, PULSE_HALF_CYCLES=3, vSyncStart at edge N, and a pad model that loads on the padLatch falling edge and shifts on padPulse rise.
1. Hold reset for 3 cycles while toggling vSyncStart -> padLatch=0, padPulse=0, buttons=8'h00, valid=0 throughout and after.
2. Pad holds A+Start pressed (active-low 8'hF6) -> padLatch high cycles N+1..N+4; buttons=8'h09 and valid=1 only at N+50.
3. Pad disconnected (padData=1 constant) -> exactly 7 padPulse pulses, each 3 cycles high; buttons=8'h00; valid at N+50.
4. Pattern 8'hA5 pressed after a prior reading of 8'h09 -> buttons stays 8'h09 through N+49 and becomes 8'hA5 at N+50.
5. Second vSyncStart at N+10 -> ignored; only one latch pulse; a new vSyncStart at N+51 starts a full second transaction.
6. reset asserted at N+20 -> at N+21 padPulse=0, padLatch=0, buttons=8'h00; valid never pulses for that transaction.
